// File: rtl/bcd_complementer.sv
// Serial multi-digit BCD nines/tens complementer, one digit per clock, LSD first.
// Optional invalid-digit detection is enabled with BCD_CPL_ERR_CHECK_EN.
module bcd_complementer #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_num,
    input  logic                  in_tens,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_num,
    output logic                  out_carry,
    output logic                  out_err
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                state_q, state_d;
    logic [4*DIGITS-1:0]   opnd_q, opnd_d;
    logic [4*DIGITS-1:0]   res_q, res_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  carry_q, carry_d;
    logic                  cout_q, cout_d;
    logic                  rdy_q;
    logic [3:0]            dig, dig_res, sum;
    logic                  dig_carry, dig_bad;
`ifdef BCD_CPL_ERR_CHECK_EN
    logic                  err_q, err_d;
    logic [3:0]            dig_eff;
`endif

    always_comb begin
        dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) dig = opnd_q[4*i +: 4];
        end
    end

    always_comb begin
        dig_bad   = (dig > 4'd9);
        dig_res   = 4'd0;
        dig_carry = 1'b0;
`ifdef BCD_CPL_ERR_CHECK_EN
        // Invalid digits are treated as 9 so the result stays legal BCD.
        dig_eff = dig_bad ? 4'd9 : dig;
        sum     = 4'd9 - dig_eff + {3'b000, carry_q};
        if (sum == 4'd10) begin
            dig_carry = 1'b1;
        end else begin
            dig_res = sum;
        end
`else
        // Invalid digits wrap modulo 16 and never generate a carry.
        sum = 4'd9 - dig + {3'b000, carry_q};
        if (!dig_bad && sum == 4'd10) begin
            dig_carry = 1'b1;
        end else begin
            dig_res = sum;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef BCD_CPL_ERR_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid && rdy_q) begin
                    opnd_d  = in_num;
                    carry_d = in_tens;
                    idx_d   = '0;
`ifdef BCD_CPL_ERR_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = StCalc;
                end
            end
            StCalc: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) res_d[4*i +: 4] = dig_res;
                end
                carry_d = dig_carry;
`ifdef BCD_CPL_ERR_CHECK_EN
                err_d   = err_q | dig_bad;
`endif
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    cout_d  = dig_carry;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            opnd_q  <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef BCD_CPL_ERR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            rdy_q   <= (state_d == StIdle);
`ifdef BCD_CPL_ERR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q == StDone);
    assign out_num   = res_q;
    assign out_carry = cout_q;
`ifdef BCD_CPL_ERR_CHECK_EN
    assign out_err   = err_q;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_complementer.sv
// Scoreboard bench for bcd_complementer (DIGITS=4): directed operands, monitor pops on transfer.
module tb_bcd_complementer;

    localparam int unsigned DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_num;
    logic        in_tens;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_num;
    logic        out_carry;
    logic        out_err;

    typedef struct packed {
        logic [15:0] num;
        logic        carry;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

`ifdef BCD_CPL_ERR_CHECK_EN
    localparam logic [15:0] ERR_NUM = 16'h6087;
    localparam logic        ERR_FLG = 1'b1;
`else
    localparam logic [15:0] ERR_NUM = 16'h6F87;
    localparam logic        ERR_FLG = 1'b0;
`endif

    bcd_complementer #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_tens   (in_tens),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_carry (out_carry),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one transfer per DONE cycle with out_ready high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%0h, expected no output", out_num);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_num", {16'h0, out_num}, {16'h0, e.num});
                check("out_carry", {31'h0, out_carry}, {31'h0, e.carry});
                check("out_err", {31'h0, out_err}, {31'h0, e.err});
            end
        end
    end

    task automatic send(input logic [15:0] num, input logic tens, input logic push,
                        input logic [15:0] enum_v, input logic ecarry, input logic eerr);
        int n;
        exp_t e;
        n = 0;
        in_num   = num;
        in_tens  = tens;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'h0, 32'h1);
        end else begin
            if (push) begin
                e.num   = enum_v;
                e.carry = ecarry;
                e.err   = eerr;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            acc_cyc  = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_valid(output logic seen);
        int n;
        n = 0;
        seen = 1'b0;
        while (n < 50 && !seen) begin
            @(negedge clk);
            seen = out_valid;
            n++;
        end
        if (!seen) check("out_valid_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        logic        seen;
        logic [15:0] hold_num;
        logic        hold_c;
        int          a0;
        int          n;

        rst = 1'b1; in_valid = 1'b0; in_num = '0; in_tens = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_num", {16'h0, out_num}, 32'h0);
        check("rst_out_carry", {31'h0, out_carry}, 32'h0);
        check("rst_out_err", {31'h0, out_err}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Latency: out_valid observed DIGITS cycles after accept.
        send(16'h0375, 1'b0, 1'b1, 16'h9624, 1'b0, 1'b0);
        a0 = acc_cyc;
        wait_valid(seen);
        if (seen) check("latency", cyc - a0, DIGITS);

        send(16'h0375, 1'b1, 1'b1, 16'h9625, 1'b0, 1'b0);
        send(16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        send(16'h9999, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        send(16'h1000, 1'b1, 1'b1, 16'h9000, 1'b0, 1'b0);
        send(16'h3A12, 1'b0, 1'b1, ERR_NUM, 1'b0, ERR_FLG);
        send(16'h0375, 1'b0, 1'b1, 16'h9624, 1'b0, 1'b0);

        // Back-to-back accept interval.
        send(16'h4321, 1'b0, 1'b1, 16'h5678, 1'b0, 1'b0);
        a0 = acc_cyc;
        send(16'h0010, 1'b1, 1'b1, 16'h9990, 1'b0, 1'b0);
        check("issue_interval", acc_cyc - a0, DIGITS + 2);

        // Backpressure: outputs hold while out_ready is low.
        wait_valid(seen);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(16'h0999, 1'b1, 1'b1, 16'h9001, 1'b0, 1'b0);
        wait_valid(seen);
        hold_num = out_num;
        hold_c   = out_carry;
        check("bp_first_num", {16'h0, out_num}, 32'h9001);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {31'h0, out_valid}, 32'h1);
            check("bp_in_ready", {31'h0, in_ready}, 32'h0);
            check("bp_num_stable", {16'h0, out_num}, {16'h0, hold_num});
            check("bp_carry_stable", {31'h0, out_carry}, {31'h0, hold_c});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", {31'h0, in_ready}, 32'h1);
        check("bp_release_valid", {31'h0, out_valid}, 32'h0);

        // Reset during the second CALC cycle discards the operation.
        send(16'h1234, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_num", {16'h0, out_num}, 32'h0);
        check("midrst_carry", {31'h0, out_carry}, 32'h0);
        check("midrst_err", {31'h0, out_err}, 32'h0);
        check("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_valid", {31'h0, out_valid}, 32'h0);
        end
        send(16'h0001, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("scoreboard_drained", exp_q.size(), 32'h0);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_complementer.md
# bcd_complementer

Parametrised multi-digit BCD complement unit: accepts a DIGITS-wide packed BCD operand and returns its nines or tens complement. Digits are processed serially, one per clock, LSD first. Valid/ready handshakes on both sides. Sits between BCD operand registers and the decimal adder, where it provides subtraction by complement-and-add.

## Interface

Parameters:
- DIGITS, 4, number of BCD digits per operand; legal range 1..16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  unit can accept an operand.
- in_num  input  4*DIGITS  packed BCD operand; digit 0 in bits [3:0].
- in_tens  input  1  0 = nines complement, 1 = tens complement; sampled at accept.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_num  output  4*DIGITS  packed BCD result.
- out_carry  output  1  carry out of the MSD (tens complement of zero gives 1).
- out_err  output  1  an invalid digit (>9) was seen in this operand; present only as functional with BCD_CPL_ERR_CHECK_EN.

## Operation

- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid & in_ready: capture in_num and in_tens, set digit index to 0, set carry to in_tens, clear error flag, go to CALC.
- CALC: in_ready=0. Per cycle, process digit d at the current index: s = (9 - d) + carry. If s == 10, write digit 0 and set carry=1; otherwise write s[3:0] and set carry=0. Increment the index. After digit DIGITS-1, latch the final carry into out_carry and go to DONE.
- DONE: out_valid=1. out_num, out_carry and out_err stay stable until out_ready=1. Then go to IDLE and deassert out_valid.
- The operand register is not overwritten while in CALC or DONE.
- Arithmetic is 4-bit per digit. The index counter is $clog2(DIGITS) bits wide, with a minimum of 1.
- in_tens=0 never produces carry=1 for valid digits. out_carry=1 only when the tens-complemented operand is all zeros.

## Timing

- Reset values: in_ready=0 during the reset cycle, then 1. out_valid=0, out_num=0, out_carry=0, out_err=0. State returns to IDLE.
- Latency: the accept edge is cycle 0, and out_valid rises at the edge ending cycle DIGITS.
- Minimum issue interval is DIGITS+2 cycles (CALC × DIGITS, DONE ×1 when out_ready=1, IDLE ×1).
- If out_ready is already high when out_valid rises, the transfer completes that cycle.
- in_ready depends only on state and never combinationally on in_valid. There are no combinational paths from inputs to outputs.
- Reset in CALC or DONE: the partial result is discarded and there is no out_valid pulse. The next cycle is IDLE with all outputs at reset values.
- DIGITS=1: CALC lasts exactly one cycle.

## Configuration

- Macro: BCD_CPL_ERR_CHECK_EN.
- Defined:
  - A digit >9 is processed as 9, so its result digit is 0 + carry-in, with normal carry rules.
  - out_err is sticky for the operation and is reported with out_valid.
- Undefined:
  - out_err is tied 0.
  - A digit >9 is computed as (9 - d + carry) mod 16, with carry=0 out. For example, d=0xA with carry 0 gives 0xF.

## Test plan

- DIGITS=4, in_num=0x0375, in_tens=0 -> out_num=0x9624, out_carry=0, out_valid exactly 4 cycles after accept.
- in_num=0x0375, in_tens=1 -> out_num=0x9625, out_carry=0. Also in_num=0x0000, in_tens=1 -> out_num=0x0000, out_carry=1.
- in_num=0x9999, in_tens=0 -> 0x0000, carry 0. Then in_num=0x1000, in_tens=1 -> 0x9000, carry 0 (borrow ripples through three zero digits).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0 throughout. out_ready=1 -> in_ready=1 the next cycle. Back-to-back operands give an accept interval of DIGITS+2.
- With the macro, in_num=0x3A12, in_tens=0 -> out_num=0x6087, out_err=1, then out_err=0 for the next valid operand. Without the macro, the same input gives 0x6F87 and out_err=0.
- Assert rst for one cycle in the second CALC cycle -> no out_valid, outputs zero. A fresh operand 0x0001 (tens) gives 0x9999, carry 0.
